// File: rtl/rcv_field_shifter_if.sv
// rcv_field_shifter_if: bit-stream, field-select and captured-field bundle between bit timing, rcu and the field shifter
//   master: drives shift_enable, d_orig, eop, *_rcving; observes fields, shift enables, done pulses, stuff_error
//   slave : the field shifter itself
interface rcv_field_shifter_if;
    logic        shift_enable;
    logic        d_orig;
    logic        eop;
    logic        sync_rcving;
    logic        pid_rcving;
    logic        crc5_rcving;
    logic        crc16_rcving;
    logic        data_rcving;
    logic [7:0]  rcv_sync;
    logic [7:0]  rcv_pid;
    logic [4:0]  rcv_crc5;
    logic [15:0] rcv_crc16;
    logic [63:0] rcv_data;
    logic        sync_shift_enable;
    logic        pid_shift_enable;
    logic        crc5_shift_enable;
    logic        crc16_shift_enable;
    logic        data_shift_enable;
    logic        sync_bits_received;
    logic        pid_bits_received;
    logic        crc5_bits_received;
    logic        crc16_bits_received;
    logic        data_bits_received;
    logic        stuff_error;
    modport master (
        output shift_enable, d_orig, eop, sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving,
        input  rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data,
        input  sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable, data_shift_enable,
        input  sync_bits_received, pid_bits_received, crc5_bits_received, crc16_bits_received, data_bits_received,
        input  stuff_error
    );
    modport slave (
        input  shift_enable, d_orig, eop, sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving,
        output rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data,
        output sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable, data_shift_enable,
        output sync_bits_received, pid_bits_received, crc5_bits_received, crc16_bits_received, data_bits_received,
        output stuff_error
    );
endinterface

// File: rtl/rcv_field_shifter.sv
// rcv_field_shifter: de-stuffs the decoded bit stream and shifts each bit LSB-first into the field selected by rcu
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : slave side of rcv_field_shifter_if (strobe/bit/eop/field selects in; fields, shift enables,
//                one-cycle field-complete pulses and stuff_error out)
module rcv_field_shifter (
    input logic clk,
    input logic n_rst,
    rcv_field_shifter_if.slave bus
);
    typedef enum logic [2:0] {F_NONE, F_SYNC, F_PID, F_CRC5, F_CRC16, F_DATA} field_t;
    field_t      cur_field, cur_field_n, act;
    logic [6:0]  bit_cnt, bit_cnt_n, cnt, flen;
    logic [2:0]  ones_cnt, ones_cnt_n;
    logic        idle, start, cand, stuffed, accept, done_n, stuff_error;
    logic [4:0]  sel, acc, clr, rcvd;
    logic [7:0]  sync_r, pid_r;
    logic [4:0]  crc5_r;
    logic [15:0] crc16_r;
    logic [63:0] data_r;
    always_comb begin
        act = bus.sync_rcving ? F_SYNC : bus.pid_rcving ? F_PID : bus.crc5_rcving ? F_CRC5 :
              bus.crc16_rcving ? F_CRC16 : bus.data_rcving ? F_DATA : F_NONE;
        flen = (act == F_SYNC || act == F_PID) ? 7'd8 : act == F_CRC5 ? 7'd5 :
               act == F_CRC16 ? 7'd16 : act == F_DATA ? 7'd64 : 7'd0;
        sel = {act == F_DATA, act == F_CRC16, act == F_CRC5, act == F_PID, act == F_SYNC};
        // eop wins over everything, including the start of a new field
        start = act != F_NONE && act != cur_field && !bus.eop;
        cnt = start ? 7'd0 : bit_cnt;
        cand = bus.shift_enable && !bus.eop && act != F_NONE && cnt < flen;
        stuffed = cand && ones_cnt == 3'd6;
        accept = cand && !stuffed;
        done_n = accept && (cnt + 7'd1 == flen);
        acc = sel & {5{accept}};
        clr = sel & {5{start}};
        cur_field_n = cur_field;
        bit_cnt_n = bit_cnt;
        ones_cnt_n = ones_cnt;
        // idle only tracks the previous cycle, so a single-cycle gap keeps the field open
        if (bus.eop || (act == F_NONE && idle)) begin
            cur_field_n = F_NONE;
            bit_cnt_n = 7'd0;
            ones_cnt_n = 3'd0;
        end else if (act != F_NONE) begin
            cur_field_n = act;
            bit_cnt_n = cnt + {6'd0, accept};
            ones_cnt_n = stuffed ? 3'd0 : !accept ? ones_cnt : bus.d_orig ? ones_cnt + 3'd1 : 3'd0;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_field <= F_NONE;
            bit_cnt <= 7'd0;
            ones_cnt <= 3'd0;
            idle <= 1'b0;
            rcvd <= 5'd0;
            stuff_error <= 1'b0;
        end else begin
            cur_field <= cur_field_n;
            bit_cnt <= bit_cnt_n;
            ones_cnt <= ones_cnt_n;
            idle <= act == F_NONE;
            rcvd <= done_n ? sel : 5'd0;
            stuff_error <= stuffed && bus.d_orig;
        end
    end
    // a clear and a shift in the same cycle leaves {d_orig, zeros}
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_r <= '0;
            pid_r <= '0;
            crc5_r <= '0;
            crc16_r <= '0;
            data_r <= '0;
        end else begin
            sync_r <= acc[0] ? {bus.d_orig, clr[0] ? 7'd0 : sync_r[7:1]} : clr[0] ? 8'd0 : sync_r;
            pid_r <= acc[1] ? {bus.d_orig, clr[1] ? 7'd0 : pid_r[7:1]} : clr[1] ? 8'd0 : pid_r;
            crc5_r <= acc[2] ? {bus.d_orig, clr[2] ? 4'd0 : crc5_r[4:1]} : clr[2] ? 5'd0 : crc5_r;
            crc16_r <= acc[3] ? {bus.d_orig, clr[3] ? 15'd0 : crc16_r[15:1]} : clr[3] ? 16'd0 : crc16_r;
            data_r <= acc[4] ? {bus.d_orig, clr[4] ? 63'd0 : data_r[63:1]} : clr[4] ? 64'd0 : data_r;
        end
    end
    assign bus.rcv_sync = sync_r;
    assign bus.rcv_pid = pid_r;
    assign bus.rcv_crc5 = crc5_r;
    assign bus.rcv_crc16 = crc16_r;
    assign bus.rcv_data = data_r;
    assign bus.sync_shift_enable = acc[0];
    assign bus.pid_shift_enable = acc[1];
    assign bus.crc5_shift_enable = acc[2];
    assign bus.crc16_shift_enable = acc[3];
    assign bus.data_shift_enable = acc[4];
    assign bus.sync_bits_received = rcvd[0];
    assign bus.pid_bits_received = rcvd[1];
    assign bus.crc5_bits_received = rcvd[2];
    assign bus.crc16_bits_received = rcvd[3];
    assign bus.data_bits_received = rcvd[4];
    assign bus.stuff_error = stuff_error;
endmodule

// File: tb/tb_rcv_field_shifter.sv
// tb_rcv_field_shifter: directed checks of field capture, de-stuffing, gaps, eop priority and async reset
module tb_rcv_field_shifter;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] se;
    rcv_field_shifter_if b();
    rcv_field_shifter dut (.clk(clk), .n_rst(n_rst), .bus(b));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drives one strobed bit for one cycle, captures the combinational shift enables, then idles gap cycles
    task automatic strobe(input logic d, input int gap, output logic [4:0] s);
        b.shift_enable = 1'b1;
        b.d_orig = d;
        #1;
        s = {b.data_shift_enable, b.crc16_shift_enable, b.crc5_shift_enable, b.pid_shift_enable, b.sync_shift_enable};
        @(posedge clk);
        #1;
        b.shift_enable = 1'b0;
        b.d_orig = 1'b0;
        cyc(gap);
    endtask

    function automatic logic [4:0] rcvd();
        return {b.data_bits_received, b.crc16_bits_received, b.crc5_bits_received, b.pid_bits_received, b.sync_bits_received};
    endfunction

    task automatic eop_cycle();
        b.eop = 1'b1;
        cyc(1);
        b.eop = 1'b0;
    endtask

    initial begin
        logic [7:0] pid_bits;
        logic [4:0] crc5_bits;
        b.shift_enable = 1'b0;
        b.d_orig = 1'b0;
        b.eop = 1'b0;
        b.sync_rcving = 1'b0;
        b.pid_rcving = 1'b0;
        b.crc5_rcving = 1'b0;
        b.crc16_rcving = 1'b0;
        b.data_rcving = 1'b0;
        cyc(2);
        chk("reset_sync", b.rcv_sync, 0);
        chk("reset_data", b.rcv_data, 0);
        chk("reset_rcvd", rcvd(), 0);
        chk("reset_stuff", b.stuff_error, 0);
        n_rst = 1'b1;
        cyc(1);
        // sync 0000_0001 every 4 cycles
        b.sync_rcving = 1'b1;
        for (int i = 0; i < 7; i++) strobe(1'b0, 3, se);
        chk("sync_se_first7", se, 5'b00001);
        strobe(1'b1, 0, se);
        chk("sync_rcvd_pulse", rcvd(), 5'b00001);
        chk("sync_value", b.rcv_sync, 8'h80);
        cyc(1);
        chk("sync_rcvd_single", rcvd(), 0);
        cyc(2);
        strobe(1'b1, 0, se);
        chk("sync_9th_se", se, 0);
        chk("sync_9th_rcvd", rcvd(), 0);
        chk("sync_9th_value", b.rcv_sync, 8'h80);
        // pid 0x96 LSB-first, back-to-back
        b.sync_rcving = 1'b0;
        b.pid_rcving = 1'b1;
        pid_bits = 8'h96;
        for (int i = 0; i < 7; i++) strobe(pid_bits[i], 0, se);
        chk("pid_rcvd_early", rcvd(), 0);
        strobe(pid_bits[7], 0, se);
        chk("pid_rcvd_pulse", rcvd(), 5'b00010);
        chk("pid_value", b.rcv_pid, 8'h96);
        cyc(1);
        chk("pid_rcvd_single", rcvd(), 0);
        chk("sync_retained", b.rcv_sync, 8'h80);
        // data: six 1s, stuffed 0, 58 alternating bits
        b.pid_rcving = 1'b0;
        eop_cycle();
        b.data_rcving = 1'b1;
        for (int i = 0; i < 6; i++) strobe(1'b1, 0, se);
        strobe(1'b0, 0, se);
        chk("data_stuffed_se", se, 0);
        chk("data_stuffed_noerr", b.stuff_error, 0);
        for (int i = 0; i < 57; i++) strobe(1'(i % 2), 0, se);
        chk("data_rcvd_early", rcvd(), 0);
        strobe(1'b1, 0, se);
        chk("data_65th_se", se, 5'b10000);
        chk("data_rcvd_pulse", rcvd(), 5'b10000);
        chk("data_value", b.rcv_data, 64'hAAAA_AAAA_AAAA_AABF);
        chk("data_low6", b.rcv_data[5:0], 6'h3F);
        // stuff error inside crc16
        b.data_rcving = 1'b0;
        eop_cycle();
        b.crc16_rcving = 1'b1;
        for (int i = 0; i < 6; i++) strobe(1'b1, 0, se);
        strobe(1'b1, 0, se);
        chk("crc16_stuff_se", se, 0);
        chk("crc16_stuff_err", b.stuff_error, 1);
        chk("crc16_after_stuff", b.rcv_crc16, 16'hFC00);
        for (int i = 0; i < 9; i++) strobe(1'b0, 0, se);
        chk("crc16_stuff_err_single", b.stuff_error, 0);
        chk("crc16_rcvd_early", rcvd(), 0);
        strobe(1'b0, 0, se);
        chk("crc16_rcvd_pulse", rcvd(), 5'b01000);
        chk("crc16_value", b.rcv_crc16, 16'h003F);
        // crc5 with single- and two-cycle gaps
        b.crc16_rcving = 1'b0;
        b.crc5_rcving = 1'b1;
        crc5_bits = 5'b01101;
        for (int i = 0; i < 5; i++) strobe(crc5_bits[i], 0, se);
        chk("crc5_rcvd_pulse", rcvd(), 5'b00100);
        chk("crc5_value", b.rcv_crc5, 5'b01101);
        b.crc5_rcving = 1'b0;
        cyc(1);
        b.crc5_rcving = 1'b1;
        cyc(2);
        chk("crc5_gap1_kept", b.rcv_crc5, 5'b01101);
        chk("crc5_gap1_norcvd", rcvd(), 0);
        strobe(1'b1, 0, se);
        chk("crc5_saturated_se", se, 0);
        chk("crc5_saturated_rcvd", rcvd(), 0);
        b.crc5_rcving = 1'b0;
        cyc(2);
        b.crc5_rcving = 1'b1;
        cyc(1);
        chk("crc5_gap2_cleared", b.rcv_crc5, 0);
        // reset mid-data
        b.crc5_rcving = 1'b0;
        eop_cycle();
        b.data_rcving = 1'b1;
        for (int i = 0; i < 30; i++) strobe(1'(i % 2), 0, se);
        chk("data30_value", b.rcv_data, 64'hAAAA_AAA8_0000_0000);
        n_rst = 1'b0;
        #1;
        chk("async_rst_data", b.rcv_data, 0);
        chk("async_rst_pid", b.rcv_pid, 0);
        chk("async_rst_rcvd", rcvd(), 0);
        cyc(1);
        n_rst = 1'b1;
        for (int i = 0; i < 63; i++) strobe(1'(i % 2), 0, se);
        chk("restart_rcvd_early", rcvd(), 0);
        strobe(1'b1, 0, se);
        chk("restart_rcvd_pulse", rcvd(), 5'b10000);
        chk("restart_value", b.rcv_data, 64'hAAAA_AAAA_AAAA_AAAA);
        // eop with a strobe: bit dropped; next strobe starts sync with clear+shift
        b.data_rcving = 1'b0;
        b.sync_rcving = 1'b1;
        b.eop = 1'b1;
        strobe(1'b1, 0, se);
        b.eop = 1'b0;
        chk("eop_strobe_se", se, 0);
        chk("eop_strobe_value", b.rcv_sync, 0);
        strobe(1'b1, 0, se);
        chk("start_shift_se", se, 5'b00001);
        chk("start_shift_value", b.rcv_sync, 8'h80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
